// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the two-requester serial sensor link controller.
// Holds the FSM state encoding, the requester id type and the round-robin pick.
package spi_arb_pkg;

  localparam int unsigned DEF_CLK_DIV    = 2;
  localparam int unsigned DEF_FRAME_BITS = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    QUIET = 3'd4
  } state_e;

  typedef logic req_id_t;

  // A lone request wins outright; a tie goes to whoever was not served last.
  function automatic req_id_t rr_pick(input logic [1:0] req, input req_id_t last);
    req_id_t pick;
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last;
      default: pick = 1'b0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Half-period timer for sck: counts CLK_DIV clocks per phase and emits registered
// rise/fall ticks, alternating and starting with a rise after the cs setup phase.
module spi_bit_timer
  import spi_arb_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_rise_tick,
  output logic o_fall_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_phase;
  logic          r_rise;
  logic          r_fall;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);

  // Phase counter; cleared whenever the FSM is outside SETUP/SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_cnt   <= w_wrap ? '0 : r_cnt + CW'(1);
      r_rise  <= w_wrap & ~r_phase;
      r_fall  <= w_wrap & r_phase;
      r_phase <= w_wrap ? ~r_phase : r_phase;
    end
  end

  assign o_rise_tick = r_rise & i_en;
  assign o_fall_tick = r_fall & i_en;

endmodule

// File: rtl/spi_frame_arbiter.sv
// Owns the single serial sensor link and shares it round-robin between two
// requesters, running one MSB-first read frame per grant.
module spi_frame_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            i_req,
  output logic [1:0]            o_ack,
  output logic                  o_rsp_valid,
  output req_id_t               o_rsp_id,
  output logic [FRAME_BITS-1:0] o_rsp_data,
  output logic                  o_busy,
  output logic                  o_cs,
  output logic                  o_sck,
  input  logic                  i_sdo
);

  localparam int unsigned BW = $clog2(FRAME_BITS + 1);
  localparam int unsigned QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BITS_END   = BW'(FRAME_BITS);
  localparam logic [QW-1:0] QUIET_LAST = QW'(CLK_DIV - 1);

  state_e                r_state;
  state_e                w_next;
  req_id_t               r_id;
  req_id_t               r_last;
  logic [BW-1:0]         r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic [QW-1:0]         r_quiet_cnt;
  logic                  r_cs;
  logic                  r_sck;
  logic                  r_busy;
  logic                  r_rsp_valid;
  logic [1:0]            r_ack;
  req_id_t               r_rsp_id;
  logic [FRAME_BITS-1:0] r_rsp_data;
  logic                  w_timer_en;
  logic                  w_rise;
  logic                  w_fall;
  logic                  w_bits_done;
  logic                  w_quiet_done;

  assign w_timer_en   = (r_state == SETUP) || (r_state == SHIFT);
  assign w_bits_done  = (r_bit_cnt == BITS_END);
  assign w_quiet_done = (r_quiet_cnt == QUIET_LAST);

  spi_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_en        (w_timer_en),
    .o_rise_tick (w_rise),
    .o_fall_tick (w_fall)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // SHIFT ends on the rise tick that would start period FRAME_BITS+1.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|i_req) w_next = SETUP; else w_next = IDLE;
      SETUP:   if (w_rise) w_next = SHIFT; else w_next = SETUP;
      SHIFT:   if (w_rise && w_bits_done) w_next = DONE; else w_next = SHIFT;
      DONE:    w_next = QUIET;
      QUIET:   if (w_quiet_done) w_next = IDLE; else w_next = QUIET;
      default: w_next = IDLE;
    endcase
  end

  // Link pins, arbiter, shift register and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs        <= 1'b1;
      r_sck       <= 1'b0;
      r_busy      <= 1'b0;
      r_ack       <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_quiet_cnt <= '0;
    end else begin
      r_ack       <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_busy      <= (w_next != IDLE);
      r_quiet_cnt <= (r_state == QUIET) ? r_quiet_cnt + QW'(1) : '0;
      case (r_state)
        IDLE: begin
          r_cs  <= 1'b1;
          r_sck <= 1'b0;
          if (|i_req) begin
            r_id      <= rr_pick(i_req, r_last);
            r_bit_cnt <= '0;
            r_shift   <= '0;
          end
        end
        SETUP: begin
          r_cs <= 1'b0;
          if (w_rise) r_sck <= 1'b1;
        end
        SHIFT: begin
          r_cs <= 1'b0;
          if (w_rise && !w_bits_done) begin
            r_sck <= 1'b1;
          end else if (w_fall) begin
            r_sck     <= 1'b0;
            r_shift   <= {r_shift[FRAME_BITS-2:0], i_sdo};
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
        end
        DONE: begin
          r_cs        <= 1'b1;
          r_sck       <= 1'b0;
          r_rsp_data  <= r_shift;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          r_ack       <= (r_id == 1'b1) ? 2'b10 : 2'b01;
          r_last      <= r_id;
        end
        QUIET: begin
          r_cs  <= 1'b1;
          r_sck <= 1'b0;
        end
        default: begin
          r_cs  <= 1'b1;
          r_sck <= 1'b0;
        end
      endcase
    end
  end

  assign o_cs        = r_cs;
  assign o_sck       = r_sck;
  assign o_busy      = r_busy;
  assign o_ack       = r_ack;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Scoreboard bench: a default instance (CLK_DIV=2, 16 bits) and a swept instance
// (CLK_DIV=1, 12 bits), each driven by an MSB-first sensor model.
module tb_spi_frame_arbiter;

  typedef struct packed { logic id; logic [15:0] data; } exp_t;
  typedef struct {
    logic id; logic [15:0] data; logic [1:0] ack;
    int lat; int rises; int gap; int pmin; int pmax;
  } rx_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  req_a, ack_a, req_b, ack_b;
  logic        vld_a, id_a, busy_a, cs_a, sck_a, sdo_a;
  logic        vld_b, id_b, busy_b, cs_b, sck_b, sdo_b;
  logic [15:0] data_a;
  logic [11:0] data_b;

  spi_frame_arbiter #(.CLK_DIV(2), .FRAME_BITS(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_req(req_a), .o_ack(ack_a), .o_rsp_valid(vld_a),
    .o_rsp_id(id_a), .o_rsp_data(data_a), .o_busy(busy_a), .o_cs(cs_a),
    .o_sck(sck_a), .i_sdo(sdo_a));

  spi_frame_arbiter #(.CLK_DIV(1), .FRAME_BITS(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_req(req_b), .o_ack(ack_b), .o_rsp_valid(vld_b),
    .o_rsp_id(id_b), .o_rsp_data(data_b), .o_busy(busy_b), .o_cs(cs_b),
    .o_sck(sck_b), .i_sdo(sdo_b));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] sens_q_a[$];
  logic [11:0] sens_q_b[$];
  exp_t        exp_q_a[$], exp_q_b[$];
  rx_t         rx_q_a[$], rx_q_b[$];

  // Sensor models: load a word on cs fall, present the next bit after each sck rise.
  logic [15:0] sw_a; int si_a;
  logic [11:0] sw_b; int si_b;
  initial begin sdo_a = 1'b0; sdo_b = 1'b0; sw_a = 16'h0; sw_b = 12'h0; si_a = 0; si_b = 0; end
  always @(negedge cs_a) begin
    sw_a = (sens_q_a.size() > 0) ? sens_q_a.pop_front() : 16'h0000; si_a = 15; sdo_a = 1'b0;
  end
  always @(posedge sck_a) if (si_a >= 0) begin sdo_a = sw_a[si_a]; si_a--; end
  always @(negedge cs_b) begin
    sw_b = (sens_q_b.size() > 0) ? sens_q_b.pop_front() : 12'h000; si_b = 11; sdo_b = 1'b0;
  end
  always @(posedge sck_b) if (si_b >= 0) begin sdo_b = sw_b[si_b]; si_b--; end

  // Monitors: collect each response with its latency, sck rises, cs gap and sck period.
  int g_a, r_a, csr_a, gap_a, sbad_a, spur_a; logic pb_a, ps_a, pc_a;
  int g_b, r_b, lr_b, pmin_b, pmax_b, sbad_b, spur_b; logic pb_b, ps_b;
  initial begin sbad_a = 0; spur_a = 0; sbad_b = 0; spur_b = 0; end
  always @(negedge clk) begin
    if (!rst_n) begin
      g_a = 0; r_a = 0; csr_a = -1000; gap_a = 0; pb_a = 1'b0; ps_a = 1'b0; pc_a = 1'b1;
    end else begin
      if (busy_a && !pb_a) g_a = cyc;
      if (!cs_a && pc_a) begin gap_a = cyc - csr_a; r_a = 0; end
      if (cs_a && !pc_a) csr_a = cyc;
      if (sck_a && !ps_a && !cs_a) r_a++;
      if (sck_a && cs_a) sbad_a++;
      if (ack_a != 2'b00 && !vld_a) spur_a++;
      if (vld_a) rx_q_a.push_back('{id_a, data_a, ack_a, cyc - g_a, r_a, gap_a, 0, 0});
      pb_a = busy_a; ps_a = sck_a; pc_a = cs_a;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      g_b = 0; r_b = 0; lr_b = -1; pmin_b = 1000; pmax_b = 0; pb_b = 1'b0; ps_b = 1'b0;
    end else begin
      if (busy_b && !pb_b) begin g_b = cyc; r_b = 0; lr_b = -1; pmin_b = 1000; pmax_b = 0; end
      if (sck_b && !ps_b && !cs_b) begin
        r_b++;
        if (lr_b >= 0) begin
          if (cyc - lr_b < pmin_b) pmin_b = cyc - lr_b;
          if (cyc - lr_b > pmax_b) pmax_b = cyc - lr_b;
        end
        lr_b = cyc;
      end
      if (sck_b && cs_b) sbad_b++;
      if (ack_b != 2'b00 && !vld_b) spur_b++;
      if (vld_b) rx_q_b.push_back('{id_b, {4'h0, data_b}, ack_b, cyc - g_b, r_b, 0, pmin_b, pmax_b});
      pb_b = busy_b; ps_b = sck_b;
    end
  end

  task automatic do_reset(input logic [1:0] req_during);
    req_a = req_during; req_b = 2'b00; rst_n = 1'b0;
    sens_q_a.delete(); sens_q_b.delete(); rx_q_a.delete(); rx_q_b.delete();
    exp_q_a.delete(); exp_q_b.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits for n responses; requesters whose bit is in drop_mask release req on ack.
  task automatic wait_rx(input bit sel_b, input int n, input int budget,
                         input logic [1:0] drop_mask, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (sel_b) begin
        req_b = req_b & ~(ack_b & drop_mask);
        if (rx_q_b.size() >= n) begin ok = 1'b1; return; end
      end else begin
        req_a = req_a & ~(ack_a & drop_mask);
        if (rx_q_a.size() >= n) begin ok = 1'b1; return; end
      end
    end
  endtask

  task automatic test_reset();
    req_a = 2'b00; req_b = 2'b00; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs_a !== 1'b1) begin failures++; $display("FAIL reset_cs got=%b exp=1", cs_a); end
    checks++; if (sck_a !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", sck_a); end
    checks++; if ({ack_a, vld_a, busy_a} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=0000", {ack_a, vld_a, busy_a}); end
    checks++; if ({id_a, data_a} !== 17'h0) begin
      failures++; $display("FAIL reset_rsp got=%h exp=0", {id_a, data_a}); end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok; rx_t r; exp_t e;
    sens_q_a.push_back(16'h1EE0); exp_q_a.push_back('{1'b0, 16'h1EE0});
    req_a = 2'b01;
    wait_rx(1'b0, 1, 200, 2'b01, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout got=no_rsp exp=rsp"); end
    else begin
      r = rx_q_a.pop_front(); e = exp_q_a.pop_front();
      if (r.data !== e.data) begin failures++; $display("FAIL single_data got=%h exp=%h", r.data, e.data); end
      checks++; if (r.id !== e.id) begin failures++; $display("FAIL single_id got=%b exp=%b", r.id, e.id); end
      checks++; if (r.ack !== 2'b01) begin failures++; $display("FAIL single_ack got=%b exp=01", r.ack); end
      checks++; if (r.rises != 16) begin failures++; $display("FAIL single_rises got=%0d exp=16", r.rises); end
      checks++; if (r.lat != 68) begin failures++; $display("FAIL single_latency got=%0d exp=68", r.lat); end
    end
    repeat (100) @(negedge clk);
    checks++; if (rx_q_a.size() != 0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL single_extra_frame got=%0d/%b exp=0/0", rx_q_a.size(), busy_a); end
  endtask

  task automatic test_simultaneous();
    bit ok; rx_t r; exp_t e;
    do_reset(2'b11);
    sens_q_a.push_back(16'hA5A5); sens_q_a.push_back(16'h5A5A);
    exp_q_a.push_back('{1'b0, 16'hA5A5}); exp_q_a.push_back('{1'b1, 16'h5A5A});
    wait_rx(1'b0, 2, 400, 2'b00, ok);
    req_a = 2'b00;
    checks++;
    if (!ok) begin failures++; $display("FAIL simul_timeout got=%0d exp=2", rx_q_a.size()); end
    else begin
      for (int k = 0; k < 2; k++) begin
        r = rx_q_a.pop_front(); e = exp_q_a.pop_front();
        checks++; if ({r.id, r.data} !== {e.id, e.data}) begin
          failures++; $display("FAIL simul_rsp%0d got=%b/%h exp=%b/%h", k, r.id, r.data, e.id, e.data); end
        if (k == 1) begin
          checks++; if (r.gap < 4) begin failures++; $display("FAIL simul_cs_gap got=%0d exp>=4", r.gap); end
        end
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_continuous();
    bit ok; rx_t r; exp_t e; logic [15:0] w;
    for (int k = 0; k < 4; k++) begin
      w = 16'($urandom);
      sens_q_a.push_back(w); exp_q_a.push_back('{k[0], w});
    end
    req_a = 2'b11;
    wait_rx(1'b0, 4, 800, 2'b00, ok);
    req_a = 2'b00;
    checks++;
    if (!ok) begin failures++; $display("FAIL cont_timeout got=%0d exp=4", rx_q_a.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        r = rx_q_a.pop_front(); e = exp_q_a.pop_front();
        checks++; if ({r.id, r.ack, r.data} !== {e.id, (e.id ? 2'b10 : 2'b01), e.data}) begin
          failures++; $display("FAIL cont_rsp%0d got=%b/%b/%h exp=%b/%h", k, r.id, r.ack, r.data, e.id, e.data); end
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_drop_after_grant();
    bit ok; bit fell; rx_t r; exp_t e;
    sens_q_a.push_back(16'hBEEF); exp_q_a.push_back('{1'b1, 16'hBEEF});
    req_a = 2'b10;
    fell = 1'b0;
    for (int i = 0; i < 50 && !fell; i++) begin @(negedge clk); #1; fell = !cs_a; end
    @(negedge clk); #1 req_a = 2'b00;
    wait_rx(1'b0, 1, 200, 2'b00, ok);
    checks++;
    if (!fell || !ok) begin failures++; $display("FAIL drop_timeout got=%b%b exp=11", fell, ok); end
    else begin
      r = rx_q_a.pop_front(); e = exp_q_a.pop_front();
      checks++; if ({r.id, r.ack, r.data} !== {e.id, 2'b10, e.data}) begin
        failures++; $display("FAIL drop_rsp got=%b/%b/%h exp=%b/10/%h", r.id, r.ack, r.data, e.id, e.data); end
    end
    repeat (100) @(negedge clk);
    checks++; if (rx_q_a.size() != 0 || busy_a !== 1'b0) begin
      failures++; $display("FAIL drop_extra_frame got=%0d/%b exp=0/0", rx_q_a.size(), busy_a); end
  endtask

  task automatic test_reset_mid();
    bit ok; bit hit; rx_t r; exp_t e;
    sens_q_a.push_back(16'hC3C3);
    req_a = 2'b01;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin @(negedge clk); #1; hit = (r_a >= 7); end
    rst_n = 1'b0;
    #1;
    checks++; if (!hit) begin failures++; $display("FAIL mid_no_7th_rise got=%0d exp=7", r_a); end
    checks++; if ({cs_a, sck_a} !== 2'b10) begin failures++; $display("FAIL mid_pins got=%b exp=10", {cs_a, sck_a}); end
    checks++; if ({data_a, ack_a, vld_a} !== 19'h0) begin
      failures++; $display("FAIL mid_rsp got=%h/%b/%b exp=0", data_a, ack_a, vld_a); end
    repeat (3) @(negedge clk);
    checks++; if (rx_q_a.size() != 0) begin failures++; $display("FAIL mid_ack got=%0d exp=0", rx_q_a.size()); end
    sens_q_a.delete(); sens_q_a.push_back(16'h3C5A); exp_q_a.push_back('{1'b0, 16'h3C5A});
    #1 rst_n = 1'b1;
    wait_rx(1'b0, 1, 200, 2'b01, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_retry_timeout got=no_rsp exp=rsp"); end
    else begin
      r = rx_q_a.pop_front(); e = exp_q_a.pop_front();
      checks++; if ({r.id, r.ack, r.data} !== {e.id, 2'b01, e.data}) begin
        failures++; $display("FAIL mid_retry_rsp got=%b/%b/%h exp=%b/01/%h", r.id, r.ack, r.data, e.id, e.data); end
      checks++; if (r.rises != 16 || r.lat != 68) begin
        failures++; $display("FAIL mid_retry_timing got=%0d/%0d exp=16/68", r.rises, r.lat); end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_sweep();
    bit ok; rx_t r; exp_t e;
    sens_q_b.push_back(12'hFFF); exp_q_b.push_back('{1'b0, 16'h0FFF});
    sens_q_b.push_back(12'hA5C); exp_q_b.push_back('{1'b1, 16'h0A5C});
    req_b = 2'b01;
    wait_rx(1'b1, 1, 100, 2'b01, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL sweep_timeout got=no_rsp exp=rsp"); end
    else begin
      r = rx_q_b.pop_front(); e = exp_q_b.pop_front();
      checks++; if ({r.id, r.ack, r.data} !== {e.id, 2'b01, e.data}) begin
        failures++; $display("FAIL sweep_rsp got=%b/%b/%h exp=%b/01/%h", r.id, r.ack, r.data, e.id, e.data); end
      checks++; if (r.lat != 27) begin failures++; $display("FAIL sweep_latency got=%0d exp=27", r.lat); end
      checks++; if (r.rises != 12) begin failures++; $display("FAIL sweep_rises got=%0d exp=12", r.rises); end
      checks++; if (r.pmin != 2 || r.pmax != 2) begin
        failures++; $display("FAIL sweep_period got=%0d..%0d exp=2", r.pmin, r.pmax); end
    end
    repeat (5) @(negedge clk);
    #1 req_b = 2'b10;
    wait_rx(1'b1, 1, 100, 2'b10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL sweep2_timeout got=no_rsp exp=rsp"); end
    else begin
      r = rx_q_b.pop_front(); e = exp_q_b.pop_front();
      checks++; if ({r.id, r.ack, r.data} !== {e.id, 2'b10, e.data}) begin
        failures++; $display("FAIL sweep2_rsp got=%b/%b/%h exp=%b/10/%h", r.id, r.ack, r.data, e.id, e.data); end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_link_hygiene();
    checks++; if (sbad_a != 0 || sbad_b != 0) begin
      failures++; $display("FAIL sck_while_cs_high got=%0d/%0d exp=0/0", sbad_a, sbad_b); end
    checks++; if (spur_a != 0 || spur_b != 0) begin
      failures++; $display("FAIL ack_without_valid got=%0d/%0d exp=0/0", spur_a, spur_b); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_continuous();
    test_drop_after_grant();
    test_reset_mid();
    test_sweep();
    test_link_hygiene();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
